// File: rtl/fifo_arbiter.sv
// Round-robin arbiter that lets NREQ producers share one FIFO write port, with bursts of up to BURST beats.
// Define FIFO_ARB_PRIO_EN to make requester 0 win every arbitration in which it is valid.
module fifo_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_wr_en_o,
  output logic [WIDTH-1:0]        fifo_din_o,
  output logic [NREQ-1:0]         grant_o,
  output logic                    busy_o
);

  // state | meaning
  // IDLE  | no owner; pick the next requester (one bubble cycle)
  // GRANT | owner streams beats until BURST beats, valid drop, or reset

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   pick;
  logic            found;
  logic            own_valid;
  logic [NREQ-1:0] grant_oh;

  // First valid requester after last_q, wrapping.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid_i[IW'((int'(last_q) + k) % NREQ)]) begin
        found = 1'b1;
        pick  = IW'((int'(last_q) + k) % NREQ);
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid_i[0]) pick = '0;
`endif
  end

  assign own_valid = req_valid_i[owner_q];
  assign grant_oh  = NREQ'(1) << owner_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    grant_o      = '0;
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_din_o   = '0;
    busy_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy_o       = 1'b1;
        grant_o      = grant_oh;
        req_ready_o  = fifo_full_i ? '0 : grant_oh;
        fifo_wr_en_o = own_valid & !fifo_full_i;
        fifo_din_o   = req_data_i[int'(owner_q)*WIDTH +: WIDTH];
        if (!own_valid) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (!fifo_full_i) begin
          if (cnt_q == CW'(BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so suppress outputs combinationally to avoid a write in the reset cycle.
    if (!rst_n) begin
      grant_o      = '0;
      req_ready_o  = '0;
      fifo_wr_en_o = 1'b0;
      fifo_din_o   = '0;
      busy_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
